// File: rtl/median_window_ctrl.sv
// Sliding-window median controller: paces sample insertions into a chain of sort cells
// and returns the rank-K value of every full window on a valid/ready port.
module median_window_ctrl #(
    parameter int unsigned R_WIDTH    = 8,
    parameter int unsigned N          = 3,
    parameter int unsigned K          = N / 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned F_WIDTH    = $clog2(N + 1)
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [R_WIDTH-1:0]   s_data,
    output logic                 arr_incre_en,
    output logic [R_WIDTH-1:0]   arr_X,
    input  logic [N*R_WIDTH-1:0] arr_R_flat,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [R_WIDTH-1:0]   m_data,
    output logic [F_WIDTH-1:0]   fill_level,
    output logic                 underrun,
    output logic                 overrun,
    input  logic                 clr_flags
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {StIdle, StRun} state_e;

    state_e             state;
    logic               ph;
    logic               cap_pend;
    logic [R_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [AW:0]        count;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic insert;
    logic starve;
    logic fill_full;
    logic capture;
    logic unused_rbus;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign s_ready    = ~fifo_full;
    assign push       = s_valid & ~fifo_full;
    // Pops only on the edge closing a ph=1 cycle, so arr_X is stable through the ph=0 cycle.
    assign pop        = ph & ~fifo_empty;
    assign insert     = ~ph & arr_incre_en;
    assign starve     = ph & fifo_empty & (state == StRun);
    assign fill_full  = (fill_level == F_WIDTH'(N));
    // cap_pend marks an insertion one ph=0 edge ago; the chain has settled by now.
    assign capture    = ~ph & cap_pend & fill_full;
    assign unused_rbus = ^arr_R_flat;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            state        <= StIdle;
            ph           <= 1'b0;
            cap_pend     <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            arr_incre_en <= 1'b0;
            arr_X        <= '0;
            fill_level   <= '0;
            m_valid      <= 1'b0;
            m_data       <= '0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ph     <= ~ph;
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW + 1)'(push) - (AW + 1)'(pop);

            if (pop) begin
                arr_X        <= mem[rd_ptr];
                arr_incre_en <= 1'b1;
                state        <= StRun;
            end else if (starve) begin
                arr_incre_en <= 1'b0;
                state        <= StIdle;
            end

            if (starve) begin
                fill_level <= '0;
            end else if (insert && !fill_full) begin
                fill_level <= fill_level + F_WIDTH'(1);
            end

            if (!ph) begin
                cap_pend <= insert;
            end

            if (capture) begin
                m_data  <= arr_R_flat[K*R_WIDTH +: R_WIDTH];
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            underrun <= (underrun & ~clr_flags) | starve;
            overrun  <= (overrun & ~clr_flags) | (capture & m_valid & ~m_ready);
        end
    end

endmodule
